// File: rtl/mux_pipe_reg.sv
// N:1 select with a registered valid/ready output stage.
// Define MUX_PIPE_SKID_EN for a two-entry skid buffer with a registered in_ready.
module mux_pipe_reg #(
   parameter int WIDTH = 24,
   parameter int N     = 4,
   localparam int SELW = $clog2(N)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [SELW-1:0]      sel,
   input  logic [N*WIDTH-1:0]   in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic [SELW-1:0]      out_sel,
   output logic                 sel_err
);

   localparam logic [SELW:0] NVAL = N[SELW:0];

   logic [WIDTH-1:0] cap_data;
   logic             cap_err;
   logic             xfer;
   logic             drain;

   // Out-of-range selects match no input and leave the captured data at zero.
   always_comb begin
      cap_data = '0;
      cap_err  = ({1'b0, sel} >= NVAL);
      for (int k = 0; k < N; k++) begin
         if (sel == k[SELW-1:0]) cap_data = in_data[k*WIDTH +: WIDTH];
      end
   end

   assign xfer  = in_valid & in_ready;
   assign drain = out_valid & out_ready;

`ifdef MUX_PIPE_SKID_EN

   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

   state_t           state, state_nxt;
   logic             rdy_q;
   logic [WIDTH-1:0] skid_data;
   logic [SELW-1:0]  skid_sel;
   logic             skid_err;
   logic             load_main, load_skid, move_skid;

   assign in_ready  = !rst & rdy_q;
   assign out_valid = (state != EMPTY);

   always_comb begin
      state_nxt = state;
      case (state)
         EMPTY:   if (xfer) state_nxt = ONE;
         ONE: begin
            if (xfer && !drain)      state_nxt = FULL;
            else if (!xfer && drain) state_nxt = EMPTY;
         end
         FULL:    if (drain) state_nxt = ONE;
         default: state_nxt = EMPTY;
      endcase
      if (flush) state_nxt = EMPTY;
   end

   // Main takes new data only when it is empty or being drained, so it holds under stall.
   assign load_main = !flush && xfer && (state == EMPTY || (state == ONE && drain));
   assign load_skid = !flush && xfer && state == ONE && !drain;
   assign move_skid = !flush && state == FULL && drain;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= EMPTY;
         rdy_q     <= 1'b1;
         out_data  <= '0;
         out_sel   <= '0;
         sel_err   <= 1'b0;
         skid_data <= '0;
         skid_sel  <= '0;
         skid_err  <= 1'b0;
      end else begin
         state <= state_nxt;
         rdy_q <= (state_nxt != FULL);
         if (load_main) begin
            out_data <= cap_data;
            out_sel  <= sel;
            sel_err  <= cap_err;
         end else if (move_skid) begin
            out_data <= skid_data;
            out_sel  <= skid_sel;
            sel_err  <= skid_err;
         end
         if (load_skid) begin
            skid_data <= cap_data;
            skid_sel  <= sel;
            skid_err  <= cap_err;
         end
      end
   end

`else

   // Accepting while draining keeps full throughput at the cost of a comb path from out_ready.
   assign in_ready = !rst & (!out_valid | out_ready);

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
         sel_err   <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (xfer) begin
         out_valid <= 1'b1;
         out_data  <= cap_data;
         out_sel   <= sel;
         sel_err   <= cap_err;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

`endif

endmodule
